// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI widths and arbiter state encoding.
package obi_pkg;
    localparam int OBI_AW  = 32;
    localparam int OBI_DW  = 32;
    localparam int OBI_BEW = 4;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_RESP} arb_state_e;
endpackage

// File: rtl/obi_rr_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder, first set req at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);
    localparam int IW = $clog2(N);

    // Scan from farthest to nearest so the entry closest to ptr is written last.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI secondary among N_PRIM primaries,
// one transaction at a time, with a per-phase watchdog that aborts with an error response.
module obi_rr_arbiter
    import obi_pkg::*;
#(
    parameter int                N_PRIM    = 4,
    parameter int                TIMEOUT   = 1024,
    parameter logic [OBI_DW-1:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_PRIM-1:0]         prim_req_i,
    output logic [N_PRIM-1:0]         prim_gnt_o,
    input  logic [OBI_AW*N_PRIM-1:0]  prim_addr_i,
    input  logic [N_PRIM-1:0]         prim_we_i,
    input  logic [OBI_BEW*N_PRIM-1:0] prim_be_i,
    input  logic [OBI_DW*N_PRIM-1:0]  prim_wdata_i,
    output logic [N_PRIM-1:0]         prim_rvalid_o,
    output logic [OBI_DW-1:0]         prim_rdata_o,
    output logic                      prim_err_o,
    output logic                      sec_req_o,
    input  logic                      sec_gnt_i,
    output logic [OBI_AW-1:0]         sec_addr_o,
    output logic                      sec_we_o,
    output logic [OBI_BEW-1:0]        sec_be_o,
    output logic [OBI_DW-1:0]         sec_wdata_o,
    input  logic                      sec_rvalid_i,
    input  logic [OBI_DW-1:0]         sec_rdata_i,
    output logic                      busy_o
);
    localparam int OW = $clog2(N_PRIM);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, owner_nxt;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic              abort_q, abort_d;
    logic [OBI_DW-1:0] rdata_q, rdata_d;
    logic              pick_valid, in_addr, own_req, expire, hs, addr_abort, resp_ok, resp_err;

    rr_pick #(.N(N_PRIM)) u_pick (
        .req_i  (prim_req_i),
        .ptr_i  (rr_ptr_q),
        .idx_o  (pick_idx),
        .valid_o(pick_valid)
    );

    assign in_addr    = state_q == ARB_ADDR;
    assign own_req    = prim_req_i[owner_q];
    assign expire     = TIMEOUT != 0 && int'(wdog_q) == TIMEOUT - 1;
    // A real handshake in the expiry cycle takes precedence over the abort.
    assign hs         = in_addr && own_req && sec_gnt_i;
    assign addr_abort = in_addr && own_req && !sec_gnt_i && expire;
    assign resp_ok    = state_q == ARB_RESP && !abort_q && sec_rvalid_i;
    assign resp_err   = state_q == ARB_RESP && !resp_ok && (abort_q || expire);
    assign owner_nxt  = owner_q == OW'(N_PRIM - 1) ? '0 : owner_q + OW'(1);

    assign sec_req_o     = in_addr && own_req;
    assign sec_addr_o    = in_addr ? prim_addr_i[OBI_AW*owner_q +: OBI_AW] : '0;
    assign sec_we_o      = in_addr && prim_we_i[owner_q];
    assign sec_be_o      = in_addr ? prim_be_i[OBI_BEW*owner_q +: OBI_BEW] : '0;
    assign sec_wdata_o   = in_addr ? prim_wdata_i[OBI_DW*owner_q +: OBI_DW] : '0;
    assign prim_gnt_o    = (hs || addr_abort) ? N_PRIM'(1) << owner_q : '0;
    assign prim_rvalid_o = (resp_ok || resp_err) ? N_PRIM'(1) << owner_q : '0;
    assign prim_rdata_o  = resp_ok ? sec_rdata_i : resp_err ? ERR_RDATA : rdata_q;
    assign prim_err_o    = resp_err;
    assign busy_o        = state_q != ARB_IDLE;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        abort_d  = abort_q;
        rdata_d  = prim_rdata_o;
        case (state_q)
            ARB_IDLE: if (pick_valid) begin
                state_d = ARB_ADDR;
                owner_d = pick_idx;
            end
            ARB_ADDR: if (hs || addr_abort) begin
                state_d = ARB_RESP;
                abort_d = addr_abort;
            end else if (!own_req) state_d = ARB_IDLE;
            default: if (resp_ok || resp_err) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = owner_nxt;
                abort_d  = 1'b0;
            end
        endcase
        wdog_d = (state_d != state_q || state_q == ARB_IDLE) ? '0 : wdog_q + WW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            abort_q  <= 1'b0;
            rdata_q  <= ERR_RDATA;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            abort_q  <= abort_d;
            rdata_q  <= rdata_d;
        end
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed stimulus with a scoreboard of expected grants and responses.
module tb_obi_rr_arbiter;
    import obi_pkg::*;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [N-1:0] vec;
        logic [31:0]  rdata;
        logic         err;
    } resp_t;

    logic            clk_i = 1'b0, rst_i = 1'b1;
    logic [N-1:0]    prim_req_i = '0, prim_we_i = '0, prim_gnt_o, prim_rvalid_o;
    logic [32*N-1:0] prim_addr_i = '0, prim_wdata_i = '0;
    logic [4*N-1:0]  prim_be_i = '0;
    logic [31:0]     prim_rdata_o, sec_addr_o, sec_wdata_o, sec_rdata_i = '0;
    logic            prim_err_o, sec_req_o, sec_gnt_i = 1'b0, sec_we_o, sec_rvalid_i = 1'b0, busy_o;
    logic [3:0]      sec_be_o;

    logic [N-1:0] gnt_q[$];
    resp_t        resp_q[$];
    int           n_chk = 0, n_fail = 0;
    logic [31:0]  addr_tbl[N] = '{32'h0000_0A00, 32'h0000_0100, 32'h0000_0C00, 32'h0000_0D00};
    int           order[5] = '{0, 1, 2, 3, 0};

    obi_rr_arbiter #(.N_PRIM(N), .TIMEOUT(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .prim_req_i(prim_req_i), .prim_gnt_o(prim_gnt_o),
        .prim_addr_i(prim_addr_i), .prim_we_i(prim_we_i), .prim_be_i(prim_be_i),
        .prim_wdata_i(prim_wdata_i), .prim_rvalid_o(prim_rvalid_o),
        .prim_rdata_o(prim_rdata_o), .prim_err_o(prim_err_o),
        .sec_req_o(sec_req_o), .sec_gnt_i(sec_gnt_i), .sec_addr_o(sec_addr_o),
        .sec_we_o(sec_we_o), .sec_be_o(sec_be_o), .sec_wdata_o(sec_wdata_o),
        .sec_rvalid_i(sec_rvalid_i), .sec_rdata_i(sec_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic exp_resp(logic [N-1:0] v, logic [31:0] d, logic e);
        resp_t r;
        r.vec = v;
        r.rdata = d;
        r.err = e;
        resp_q.push_back(r);
    endtask

    // Monitor: an expectation is pushed for exactly the cycle it must appear in.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk_i);
            if (gnt_q.size() != 0) chk("prim_gnt_o", 32'(prim_gnt_o), 32'(gnt_q.pop_front()));
            else if (prim_gnt_o != '0) chk("prim_gnt_o unexpected", 32'(prim_gnt_o), 32'd0);
            if (resp_q.size() != 0) begin
                r = resp_q.pop_front();
                chk("prim_rvalid_o", 32'(prim_rvalid_o), 32'(r.vec));
                chk("prim_rdata_o", prim_rdata_o, r.rdata);
                chk("prim_err_o", 32'(prim_err_o), 32'(r.err));
            end else if (prim_rvalid_o != '0) chk("prim_rvalid_o unexpected", 32'(prim_rvalid_o), 32'd0);
        end
    end

    initial begin
        for (int k = 0; k < N; k++) prim_addr_i[32*k +: 32] = addr_tbl[k];
        prim_be_i = '1;
        cyc(2);
        chk("rst busy_o", 32'(busy_o), 32'd0);
        chk("rst sec_req_o", 32'(sec_req_o), 32'd0);
        chk("rst sec_addr_o", sec_addr_o, 32'd0);
        chk("rst prim_err_o", 32'(prim_err_o), 32'd0);
        chk("rst prim_rdata_o", prim_rdata_o, 32'hDEADBEEF);
        rst_i = 1'b0;

        // single read from primary 1
        prim_req_i = 4'b0010;
        #1 chk("t1 idle sec_req_o", 32'(sec_req_o), 32'd0);
        cyc();
        chk("t1 sec_req_o", 32'(sec_req_o), 32'd1);
        chk("t1 sec_addr_o", sec_addr_o, 32'h100);
        sec_gnt_i = 1'b1;
        gnt_q.push_back(4'b0010);
        cyc();
        sec_gnt_i = 1'b0;
        prim_req_i = '0;
        chk("t1 resp sec_req_o", 32'(sec_req_o), 32'd0);
        sec_rvalid_i = 1'b1;
        sec_rdata_i = 32'h12345678;
        exp_resp(4'b0010, 32'h12345678, 1'b0);
        cyc();
        sec_rvalid_i = 1'b0;
        chk("t1 busy_o", 32'(busy_o), 32'd0);
        chk("t1 rdata held", prim_rdata_o, 32'h12345678);

        // owner 2 locked while primary 0 requests, then primary 0 writes
        prim_req_i = 4'b0100;
        cyc();
        prim_req_i = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t3 locked sec_addr_o", sec_addr_o, addr_tbl[2]);
            cyc();
        end
        sec_gnt_i = 1'b1;
        gnt_q.push_back(4'b0100);
        #1 chk("t3 gnt sec_addr_o", sec_addr_o, addr_tbl[2]);
        cyc();
        sec_gnt_i = 1'b0;
        prim_req_i = 4'b0001;
        cyc(2);
        sec_rvalid_i = 1'b1;
        sec_rdata_i = 32'h33333333;
        exp_resp(4'b0100, 32'h33333333, 1'b0);
        cyc();
        sec_rvalid_i = 1'b0;
        prim_we_i = 4'b0001;
        prim_be_i[3:0] = 4'h3;
        prim_wdata_i[31:0] = 32'hCAFE0000;
        cyc();
        chk("t3 p0 sec_addr_o", sec_addr_o, addr_tbl[0]);
        chk("t3 p0 sec_we_o", 32'(sec_we_o), 32'd1);
        chk("t3 p0 sec_be_o", 32'(sec_be_o), 32'h3);
        chk("t3 p0 sec_wdata_o", sec_wdata_o, 32'hCAFE0000);
        sec_gnt_i = 1'b1;
        gnt_q.push_back(4'b0001);
        cyc();
        sec_gnt_i = 1'b0;
        prim_req_i = '0;
        prim_we_i = '0;
        sec_rvalid_i = 1'b1;
        sec_rdata_i = 32'h0;
        exp_resp(4'b0001, 32'h0, 1'b0);
        cyc();
        sec_rvalid_i = 1'b0;

        // watchdog abort in ADDR: slave never grants primary 3
        prim_req_i = 4'b1000;
        cyc();
        for (int i = 0; i < TO - 1; i++) begin
            chk("t4 waiting sec_req_o", 32'(sec_req_o), 32'd1);
            cyc();
        end
        gnt_q.push_back(4'b1000);
        chk("t4 abort gnt", 32'(prim_gnt_o), 32'h8);
        cyc();
        prim_req_i = '0;
        exp_resp(4'b1000, 32'hDEADBEEF, 1'b1);
        chk("t4 abort sec_req_o", 32'(sec_req_o), 32'd0);
        cyc();
        sec_rvalid_i = 1'b1;
        sec_rdata_i = 32'h55555555;
        cyc(2);
        chk("t4 late rvalid busy_o", 32'(busy_o), 32'd0);
        sec_rvalid_i = 1'b0;
        chk("t4 rdata held", prim_rdata_o, 32'hDEADBEEF);

        // rvalid coincides with RESP watchdog expiry: real response wins
        prim_req_i = 4'b0010;
        cyc();
        sec_gnt_i = 1'b1;
        gnt_q.push_back(4'b0010);
        cyc();
        sec_gnt_i = 1'b0;
        prim_req_i = '0;
        cyc(TO - 1);
        sec_rvalid_i = 1'b1;
        sec_rdata_i = 32'h600DF00D;
        exp_resp(4'b0010, 32'h600DF00D, 1'b0);
        cyc();
        sec_rvalid_i = 1'b0;
        chk("t6 busy_o", 32'(busy_o), 32'd0);

        // reset while in RESP
        prim_req_i = 4'b0100;
        cyc();
        sec_gnt_i = 1'b1;
        gnt_q.push_back(4'b0100);
        cyc();
        sec_gnt_i = 1'b0;
        prim_req_i = '0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("t5 busy_o", 32'(busy_o), 32'd0);
        chk("t5 sec_req_o", 32'(sec_req_o), 32'd0);
        chk("t5 prim_rdata_o", prim_rdata_o, 32'hDEADBEEF);

        // all primaries requesting, zero-wait slave
        prim_req_i = 4'b1111;
        sec_gnt_i = 1'b1;
        sec_rvalid_i = 1'b1;
        for (int t = 0; t < 5; t++) begin
            sec_rdata_i = 32'hC0DE0000 + 32'(t);
            cyc();
            chk("t2 sec_addr_o", sec_addr_o, addr_tbl[order[t]]);
            gnt_q.push_back(4'(1 << order[t]));
            cyc();
            exp_resp(4'(1 << order[t]), 32'hC0DE0000 + 32'(t), 1'b0);
            cyc();
        end
        prim_req_i = '0;
        sec_gnt_i = 1'b0;
        sec_rvalid_i = 1'b0;
        cyc(2);
        chk("gnt queue drained", 32'(gnt_q.size()), 32'd0);
        chk("resp queue drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
